// File: rtl/parking_pkg.sv
// Shared types and helpers for the parking gate controller: gate states,
// timer sizing and the round-robin picker used by both arbiters.
package parking_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, OPEN, DENY} gate_state_t;

  localparam int MAX_GATES = 8;

  typedef struct packed {
    logic       vld;
    logic [2:0] idx;
  } rr_t;

  // Timer counts down from N-1 to 0, so $clog2(max) bits are enough.
  function automatic int timer_w(input int open_c, input int deny_c);
    int m;
    m = (open_c > deny_c) ? open_c : deny_c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  localparam int TIMER_W = timer_w(4, 2);

  // First set bit of req at or after ptr, wrapping modulo n.
  function automatic rr_t rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
    rr_t r;
    int  g;
    r = '0;
    for (int k = 0; k < MAX_GATES; k++) begin
      g = (int'(ptr) + k) % n;
      if (k < n && !r.vld && req[g]) begin
        r.vld = 1'b1;
        r.idx = 3'(g);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/parking_gate_fsm.sv
// One barrier: waits on a rising req edge, then opens or shows "full"
// for a fixed number of cycles once the arbiter decides.
module parking_gate_fsm
  import parking_pkg::*;
#(
  parameter bit IS_ENTRY    = 1'b1,
  parameter int OPEN_CYCLES = 4,
  parameter int DENY_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic is_uni,
  input  logic grant,
  input  logic refuse,
  output logic waiting,
  output logic car_type,
  output logic open,
  output logic denied
);
  localparam int TW = timer_w(OPEN_CYCLES, DENY_CYCLES);

  gate_state_t   state;
  logic          req_q;
  logic [TW-1:0] tmr;

  // A car that has already left is never offered to the arbiter.
  assign waiting = (state == WAIT) && req;

  // req_q resets high so a req held through reset must drop and rise again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      req_q    <= 1'b1;
      tmr      <= '0;
      car_type <= 1'b0;
      open     <= 1'b0;
      denied   <= 1'b0;
    end else begin
      req_q <= req;
      case (state)
        IDLE: if (req && !req_q) begin
          state    <= WAIT;
          car_type <= is_uni;
        end
        WAIT: begin
          if (!req) begin
            state <= IDLE;
          end else if (grant) begin
            state <= OPEN;
            open  <= 1'b1;
            tmr   <= TW'(OPEN_CYCLES - 1);
          end else if (refuse && IS_ENTRY) begin
            state  <= DENY;
            denied <= 1'b1;
            tmr    <= TW'(DENY_CYCLES - 1);
          end
        end
        OPEN, DENY: begin
          if (tmr == '0) begin
            state  <= IDLE;
            open   <= 1'b0;
            denied <= 1'b0;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/parking_gate_controller.sv
// Serialises many entry/exit gates onto parking's one-event-per-cycle
// interface with round-robin arbitration and a post-grant holdoff.
module parking_gate_controller
  import parking_pkg::*;
#(
  parameter int N_ENTRY     = 2,
  parameter int N_EXIT      = 2,
  parameter int OPEN_CYCLES = 4,
  parameter int DENY_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enabled,
  input  logic [N_ENTRY-1:0] entry_req,
  input  logic [N_ENTRY-1:0] entry_is_uni,
  input  logic [N_EXIT-1:0]  exit_req,
  input  logic [N_EXIT-1:0]  exit_is_uni,
  input  logic               uni_is_vacated_space,
  input  logic               is_vacated_space,
  input  logic               fault,
  output logic               car_entered,
  output logic               is_uni_car_entered,
  output logic               car_exited,
  output logic               is_uni_car_exited,
  output logic [N_ENTRY-1:0] entry_open,
  output logic [N_ENTRY-1:0] entry_denied,
  output logic [N_EXIT-1:0]  exit_open
);
  localparam int EPW = (N_ENTRY > 1) ? $clog2(N_ENTRY) : 1;
  localparam int XPW = (N_EXIT > 1) ? $clog2(N_EXIT) : 1;

  logic [N_ENTRY-1:0] entry_wait, entry_type, entry_grant, entry_refuse;
  logic [N_EXIT-1:0]  exit_wait, exit_type, exit_grant, exit_denied;
  logic [EPW-1:0]     entry_ptr;
  logic [XPW-1:0]     exit_ptr;
  logic               holdoff;
  rr_t                entry_pick, exit_pick;
  logic               entry_arb, exit_arb, pick_uni, pick_space, exit_uni;

  always_comb begin
    exit_arb   = enabled && !fault;
    entry_arb  = exit_arb && !holdoff;
    entry_pick = rr_pick(8'(entry_wait), 3'(entry_ptr), N_ENTRY);
    exit_pick  = rr_pick(8'(exit_wait), 3'(exit_ptr), N_EXIT);
    pick_uni   = 1'b0;
    exit_uni   = 1'b0;
    for (int i = 0; i < N_ENTRY; i++)
      if (entry_pick.idx == 3'(i)) pick_uni = entry_type[i];
    for (int j = 0; j < N_EXIT; j++)
      if (exit_pick.idx == 3'(j)) exit_uni = exit_type[j];
    pick_space   = pick_uni ? uni_is_vacated_space : is_vacated_space;
    entry_grant  = '0;
    entry_refuse = '0;
    exit_grant   = '0;
    for (int i = 0; i < N_ENTRY; i++)
      if (entry_arb && entry_pick.vld && entry_pick.idx == 3'(i)) begin
        entry_grant[i]  = pick_space;
        entry_refuse[i] = !pick_space;
      end
    for (int j = 0; j < N_EXIT; j++)
      if (exit_arb && exit_pick.vld && exit_pick.idx == 3'(j)) exit_grant[j] = 1'b1;
  end

  for (genvar i = 0; i < N_ENTRY; i++) begin : g_entry
    parking_gate_fsm #(.IS_ENTRY(1'b1), .OPEN_CYCLES(OPEN_CYCLES), .DENY_CYCLES(DENY_CYCLES)) u_gate (
      .clk(clk), .rst(rst), .req(entry_req[i]), .is_uni(entry_is_uni[i]),
      .grant(entry_grant[i]), .refuse(entry_refuse[i]), .waiting(entry_wait[i]),
      .car_type(entry_type[i]), .open(entry_open[i]), .denied(entry_denied[i]));
  end

  for (genvar j = 0; j < N_EXIT; j++) begin : g_exit
    parking_gate_fsm #(.IS_ENTRY(1'b0), .OPEN_CYCLES(OPEN_CYCLES), .DENY_CYCLES(DENY_CYCLES)) u_gate (
      .clk(clk), .rst(rst), .req(exit_req[j]), .is_uni(exit_is_uni[j]),
      .grant(exit_grant[j]), .refuse(1'b0), .waiting(exit_wait[j]),
      .car_type(exit_type[j]), .open(exit_open[j]), .denied(exit_denied[j]));
  end

  // Holdoff gives parking one cycle to update its space flags after an entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_ptr          <= '0;
      exit_ptr           <= '0;
      holdoff            <= 1'b0;
      car_entered        <= 1'b0;
      is_uni_car_entered <= 1'b0;
      car_exited         <= 1'b0;
      is_uni_car_exited  <= 1'b0;
    end else begin
      holdoff            <= |entry_grant;
      car_entered        <= |entry_grant;
      is_uni_car_entered <= (|entry_grant) && pick_uni;
      car_exited         <= |exit_grant;
      is_uni_car_exited  <= (|exit_grant) && exit_uni;
      if (entry_arb && entry_pick.vld)
        entry_ptr <= EPW'((int'(entry_pick.idx) + 1) % N_ENTRY);
      if (exit_arb && exit_pick.vld)
        exit_ptr <= XPW'((int'(exit_pick.idx) + 1) % N_EXIT);
    end
  end

endmodule

// File: tb/tb_parking_gate_controller.sv
// Randomised bench: a per-gate "pending / time-left" model predicts every
// cycle's outputs into a queue that a separate monitor drains and compares.
module tb_parking_gate_controller;
  localparam int NE = 3, NX = 2, OC = 4, DC = 2;

  logic          clk = 1'b0, rst = 1'b1, enabled = 1'b0, fault = 1'b0;
  logic [NE-1:0] entry_req = '0, entry_is_uni = '0;
  logic [NX-1:0] exit_req = '0, exit_is_uni = '0;
  logic          uni_sp = 1'b1, misc_sp = 1'b1;
  logic          car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
  logic [NE-1:0] entry_open, entry_denied;
  logic [NX-1:0] exit_open;

  parking_gate_controller #(.N_ENTRY(NE), .N_EXIT(NX), .OPEN_CYCLES(OC), .DENY_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .enabled(enabled), .entry_req(entry_req), .entry_is_uni(entry_is_uni),
    .exit_req(exit_req), .exit_is_uni(exit_is_uni), .uni_is_vacated_space(uni_sp),
    .is_vacated_space(misc_sp), .fault(fault), .car_entered(car_entered),
    .is_uni_car_entered(is_uni_car_entered), .car_exited(car_exited),
    .is_uni_car_exited(is_uni_car_exited), .entry_open(entry_open),
    .entry_denied(entry_denied), .exit_open(exit_open));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit ce, ceu, cx, cxu;
    bit [NE-1:0] eo, ed;
    bit [NX-1:0] xo;
  } exp_t;
  exp_t exp_q[$];

  int errors = 0, checks = 0;

  // Reference model: a car is pending, or its barrier has N cycles left.
  bit m_epend[NE], m_euni[NE], m_eprev[NE];
  int m_eopen[NE], m_edeny[NE];
  bit m_xpend[NX], m_xuni[NX], m_xprev[NX];
  int m_xopen[NX];
  int m_eptr, m_xptr;
  bit m_hold;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin
      m_epend[i] = 0; m_euni[i] = 0; m_eprev[i] = 1; m_eopen[i] = 0; m_edeny[i] = 0;
    end
    for (int j = 0; j < NX; j++) begin
      m_xpend[j] = 0; m_xuni[j] = 0; m_xprev[j] = 1; m_xopen[j] = 0;
    end
    m_eptr = 0; m_xptr = 0; m_hold = 0;
  endtask

  task automatic push_zero(input int tag);
    exp_t z;
    z.cyc = tag; z.ce = 0; z.ceu = 0; z.cx = 0; z.cxu = 0; z.eo = '0; z.ed = '0; z.xo = '0;
    exp_q.push_back(z);
  endtask

  // Apply one clock edge's worth of rules with the current inputs.
  task automatic model_step(input int tag);
    exp_t e;
    bit arb_x, arb_e, ge, re, gx, sp;
    int pe, px, g;
    arb_x = enabled && !fault;
    arb_e = arb_x && !m_hold;
    pe = -1; px = -1;
    for (int k = 0; k < NE; k++) begin
      g = (m_eptr + k) % NE;
      if (pe < 0 && m_epend[g] && entry_req[g]) pe = g;
    end
    for (int k = 0; k < NX; k++) begin
      g = (m_xptr + k) % NX;
      if (px < 0 && m_xpend[g] && exit_req[g]) px = g;
    end
    ge = 0; re = 0; gx = 0;
    e.ceu = 0; e.cxu = 0;
    if (arb_e && pe >= 0) begin
      sp = m_euni[pe] ? uni_sp : misc_sp;
      ge = sp; re = !sp;
      e.ceu = sp && m_euni[pe];
      m_eptr = (pe + 1) % NE;
    end
    if (arb_x && px >= 0) begin
      gx = 1; e.cxu = m_xuni[px];
      m_xptr = (px + 1) % NX;
    end
    for (int i = 0; i < NE; i++) begin
      if (m_epend[i]) begin
        if (!entry_req[i]) m_epend[i] = 0;
        else if (ge && pe == i) begin m_epend[i] = 0; m_eopen[i] = OC; end
        else if (re && pe == i) begin m_epend[i] = 0; m_edeny[i] = DC; end
      end else if (m_eopen[i] > 0) m_eopen[i]--;
      else if (m_edeny[i] > 0) m_edeny[i]--;
      else if (entry_req[i] && !m_eprev[i]) begin m_epend[i] = 1; m_euni[i] = entry_is_uni[i]; end
      m_eprev[i] = entry_req[i];
      e.eo[i] = m_eopen[i] > 0;
      e.ed[i] = m_edeny[i] > 0;
    end
    for (int j = 0; j < NX; j++) begin
      if (m_xpend[j]) begin
        if (!exit_req[j]) m_xpend[j] = 0;
        else if (gx && px == j) begin m_xpend[j] = 0; m_xopen[j] = OC; end
      end else if (m_xopen[j] > 0) m_xopen[j]--;
      else if (exit_req[j] && !m_xprev[j]) begin m_xpend[j] = 1; m_xuni[j] = exit_is_uni[j]; end
      m_xprev[j] = exit_req[j];
      e.xo[j] = m_xopen[j] > 0;
    end
    m_hold = ge;
    e.cyc = tag; e.ce = ge; e.cx = gx;
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expectation per cycle and compares away from the edge.
  exp_t me;
  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      me = exp_q.pop_front();
      chk("car_entered", 8'(car_entered), 8'(me.ce));
      if (me.ce && car_entered) chk("is_uni_car_entered", 8'(is_uni_car_entered), 8'(me.ceu));
      chk("car_exited", 8'(car_exited), 8'(me.cx));
      if (me.cx && car_exited) chk("is_uni_car_exited", 8'(is_uni_car_exited), 8'(me.cxu));
      chk("entry_open", 8'(entry_open), 8'(me.eo));
      chk("entry_denied", 8'(entry_denied), 8'(me.ed));
      chk("exit_open", 8'(exit_open), 8'(me.xo));
    end
  end

  initial begin
    int flip;
    model_reset();
    push_zero(1);
    for (int it = 0; it < 1200; it++) begin
      @(posedge clk);
      #2;
      rst = (it < 3) || (it == 400) || (it == 401) || (it == 802);
      flip = (it >= 600) ? 3 : 5;
      for (int i = 0; i < NE; i++) begin
        if ($urandom_range(0, flip - 1) == 0) entry_req[i] = ~entry_req[i];
        entry_is_uni[i] = 1'($urandom_range(0, 1));
      end
      for (int j = 0; j < NX; j++) begin
        if ($urandom_range(0, flip - 1) == 0) exit_req[j] = ~exit_req[j];
        exit_is_uni[j] = 1'($urandom_range(0, 1));
      end
      enabled = ($urandom_range(0, 9) != 0);
      if (it < 300) begin
        fault = ($urandom_range(0, 29) == 0);
        uni_sp = ($urandom_range(0, 9) < 7); misc_sp = ($urandom_range(0, 9) < 7);
      end else if (it < 600) begin
        fault = ((it / 20) % 3 == 0);
        uni_sp = ($urandom_range(0, 9) < 3); misc_sp = ($urandom_range(0, 9) < 6);
      end else begin
        fault = ($urandom_range(0, 19) == 0);
        uni_sp = 1'($urandom_range(0, 1)); misc_sp = 1'($urandom_range(0, 1));
      end
      if (rst) begin
        // Reset clears outputs within the current cycle as well.
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        push_zero(cyc);
        model_reset();
        push_zero(cyc + 1);
      end else begin
        model_step(cyc + 1);
      end
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/parking_gate_controller.md
Name: parking_gate_controller

Overview:
- Sequences multiple physical entry and exit gates onto the single-event-per-cycle interface of the `parking` occupancy counter.
- Round-robin arbitrates simultaneous gate requests and checks the space flags before admitting a car.
- Drives each barrier open or deny indicator for a fixed time.
- Sits between the gate sensors and `parking`; its four pulse outputs drive `parking`'s `car_entered`/`is_uni_car_entered`/`car_exited`/`is_uni_car_exited`.

Parameters:
- N_ENTRY, 2, number of entry gates (1..8).
- N_EXIT, 2, number of exit gates (1..8).
- OPEN_CYCLES, 4, cycles a barrier stays open after a grant (>=1).
- DENY_CYCLES, 2, cycles the "full" indicator stays lit after a refusal (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- enabled  in  1  high = arbitration allowed.
- entry_req  in  N_ENTRY  car present at entry gate i.
- entry_is_uni  in  N_ENTRY  car at entry gate i is a university car.
- exit_req  in  N_EXIT  car present at exit gate j.
- exit_is_uni  in  N_EXIT  car at exit gate j is a university car.
- uni_is_vacated_space  in  1  from parking: university section has room.
- is_vacated_space  in  1  from parking: misc section has room.
- fault  in  1  from parking: counter fault.
- car_entered  out  1  one-cycle entry pulse to parking.
- is_uni_car_entered  out  1  type of that entry; valid only with car_entered.
- car_exited  out  1  one-cycle exit pulse to parking.
- is_uni_car_exited  out  1  type of that exit; valid only with car_exited.
- entry_open  out  N_ENTRY  barrier i open.
- entry_denied  out  N_ENTRY  "full" lamp at gate i.
- exit_open  out  N_EXIT  exit barrier j open.

Behaviour:
- All outputs are registered. Reset values: every output 0, all gate FSMs IDLE, both round-robin pointers 0, holdoff 0, timers 0.
- Per-gate FSM states: IDLE, WAIT, OPEN, DENY. Exit gates use IDLE, WAIT and OPEN only.
- IDLE->WAIT: on a sampled rising edge of the gate's req (the previous-cycle req is registered).
  - The type bit is latched at this transition.
  - A req held high never re-requests.
- WAIT->IDLE: if req drops before a grant (the car left); no pulse is issued.
- Entry arbitration runs each cycle when all of these hold: enabled=1, fault=0, holdoff=0.
  - Pick the first WAIT entry gate at or after entry_ptr, wrapping modulo N_ENTRY.
  - If that gate's latched type has space (uni: uni_is_vacated_space, misc: is_vacated_space), it is GRANTED:
    - gate goes to OPEN;
    - car_entered=1 and is_uni_car_entered=type on the next cycle;
    - holdoff=1 for exactly one cycle.
  - Otherwise the gate is REFUSED: gate goes to DENY, with no pulse and no holdoff.
  - After either a grant or a refusal, entry_ptr = picked+1 mod N_ENTRY.
- Holdoff blocks entry arbitration for one cycle after a grant, so `parking`'s space flags can reflect the new count. This guarantees no over-admission at capacity.
- Exit arbitration:
  - Runs when enabled=1 and fault=0; there is no space check and no holdoff.
  - Same round-robin scheme using exit_ptr.
  - On grant: gate goes to OPEN; car_exited=1 and is_uni_car_exited=type on the next cycle.
- Entry and exit grants may occur in the same cycle; both pulses are asserted together.
- Latency: req rises in cycle 0 -> WAIT at edge 1 -> grant at edge 2 -> pulse high in cycle 2..3 (one clock) -> entry_open high for OPEN_CYCLES cycles, starting the same cycle as the pulse.
- Timed states:
  - OPEN lasts OPEN_CYCLES cycles, then IDLE.
  - DENY lasts DENY_CYCLES cycles with entry_denied=1, then IDLE.
  - Neither state depends on req; a new request needs a fresh rising edge.
- enabled=0 or fault=1: no new grants; WAIT gates keep waiting; OPEN/DENY timers continue and expire normally.
- rst asserted mid-operation: immediately clears all state and outputs, including an in-flight pulse. A car that was waiting must re-present.
- Pulse outputs are never high for two consecutive cycles per direction from the same gate; at most one entry and one exit pulse per cycle.
- Pointer width is $clog2 of the gate count (minimum 1); pointers wrap modulo N.

Decomposition:
- Shared package parking_pkg holds:
  - gate_state_t enum {IDLE, WAIT, OPEN, DENY};
  - timer width constant sized from max(OPEN_CYCLES, DENY_CYCLES);
  - rr_pick function (request vector, pointer -> index, valid).
- Sub-module parking_gate_fsm: one instance per gate, parameterised by IS_ENTRY, OPEN_CYCLES and DENY_CYCLES.
  - Inputs: req, is_uni, grant, refuse.
  - Outputs: waiting, type, open, denied.
- The top level contains the two arbiters, holdoff and pulse registers.

Test Plan:
- Single misc car at entry 0, space available, all idle -> car_entered=1 with is_uni_car_entered=0 for exactly 1 cycle at edge+2; entry_open[0] high 4 cycles; then IDLE.
- entry_req=2'b11 rising together, both uni, space available -> gate 0 granted first; gate 1 granted 2 cycles later (holdoff); entry_ptr ends at 0.
- uni_is_vacated_space=0, uni car at entry 1 -> no pulse; entry_denied[1] high 2 cycles; a misc car at entry 0 in the same window is still granted.
- Simultaneous uni entry at gate 0 and misc exit at gate 1 -> car_entered and car_exited both pulse in the same cycle with correct type bits.
- fault=1 while two gates WAIT, held 5 cycles -> no pulses; OPEN timers still expire; after fault=0, grants resume in round-robin order.
- rst asserted during entry_open[0] and the car_entered cycle -> all outputs 0 immediately; a held req produces no grant until it drops and rises again.
